nmr_bstrm_seq: RTL
==================

# nmr_bstrm_seq

Table-driven sequencer that sits directly upstream of the NMR bitstream pulse datapath. It stores up to 2^DEPTH_LOG2 pulse entries, each an initial delay, a pulse width and a post-pulse delay. On command it plays the entries in order, optionally repeated, through the datapath's START/DONE handshake. Typical use is building CPMG-style echo trains from single-pulse primitives without host intervention between pulses.

## Interface
- IDLY_WIDTH, 32: initial-delay field width; matches the datapath.
- PLS_WIDTH, 32: pulse-width field width.
- EDLY_WIDTH, 32: post-pulse-delay field width.
- DEPTH_LOG2, 4: log2 of the table depth (16 entries).
- LOOP_WIDTH, 16: repeat-counter width.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- wr_en  in  1  table write strobe.
- wr_addr  in  DEPTH_LOG2  table write address.
- wr_idly / wr_pls / wr_edly  in  IDLY_WIDTH / PLS_WIDTH / EDLY_WIDTH  entry fields.
- seq_start  in  1  start request; sampled only in IDLE.
- seq_len  in  DEPTH_LOG2+1  number of entries per pass.
- loop_cnt  in  LOOP_WIDTH  number of passes.
- abort  in  1  stop after the current entry completes.
- seq_busy  out  1  sequence in progress.
- seq_done  out  1  one-cycle completion pulse.
- seq_aborted  out  1  last sequence ended by abort; valid with seq_done, held until the next seq_start.
- seq_idx  out  DEPTH_LOG2  index of the entry currently issued.
- bs_start  out  1  START to the datapath.
- bs_idly / bs_pls / bs_edly  out  field widths  entry fields to the datapath.
- bs_done  in  1  DONE from the datapath.

## Operation
- Table: register array, not reset.
  - Written when wr_en=1 and seq_busy=0.
  - Writes while busy are dropped.
- seq_len is latched at start and clamped to 2^DEPTH_LOG2. loop_cnt is latched at start; value 0 is treated as 1.
- States:
  - IDLE
    - Holds bs_start=0 and seq_busy=0.
    - On seq_start=1 with latched len=0: seq_done pulses on the next edge, seq_aborted=0, and no bs_start is issued.
    - Otherwise on seq_start=1: go to LOAD with idx=0 and pass=0.
  - LOAD
    - Registers table[idx] onto bs_idly/bs_pls/bs_edly.
    - Sets bs_start=1 on the same edge, then goes to ACK.
  - ACK
    - Holds bs_start=1 with fields stable.
    - Waits for bs_done=0, which means the datapath has left idle and captured the fields; then goes to RUN.
  - RUN
    - Holds bs_start=1.
    - On bs_done=1: sets bs_start=0 and goes to REL.
  - REL: bs_start stays 0 for exactly one cycle so the datapath can return to idle. Then:
    - abort was seen during this entry: go to IDLE, pulse seq_done, set seq_aborted=1.
    - Else idx+1<len: idx++ and go to LOAD.
    - Else pass+1<loops: idx=0, pass++, go to LOAD.
    - Else: go to IDLE and pulse seq_done.
- abort is captured into a sticky flag while busy; it never truncates an entry in progress.
- Fields never change while bs_start=1.

## Timing
- Reset values: bs_start=0, all bs_* fields=0, seq_busy=0, seq_done=0, seq_aborted=0, seq_idx=0, state IDLE.
- seq_start sampled at edge n:
  - seq_busy=1 after edge n.
  - bs_start=1 and fields valid after edge n+1.
- Per-entry sequencer overhead: LOAD + REL = 2 cycles, plus handshake sampling latency.
- Datapath done to next bs_start: bs_done seen at edge m gives bs_start=0 after m, then bs_start=1 after m+2.
- seq_done is high for one cycle, simultaneous with seq_busy falling.
- seq_start while busy is ignored.
- seq_start and abort both high in IDLE: start proceeds and abort is ignored.
- RST mid-sequence: all outputs return to reset values on that edge. The datapath shares RST.

## Configuration
- NMR_BSTRM_SEQ_LOOP_EN
  - Defined: loop_cnt is honoured as described.
  - Undefined: loop_cnt is ignored, exactly one pass is played, and the pass counter is not synthesized.

## Test plan
- Write 3 entries (idly,pls,edly) = (5,3,7), (2,4,2), (1,1,1); len=3, loops=1 -> three OUT pulses of 4, 5 and 2 cycles high, in order; one seq_done; seq_aborted=0.
- Same table, loops=4 with LOOP_EN defined -> 12 pulses and seq_idx cycles 0,1,2 four times. With the macro undefined -> 3 pulses.
- Assert abort for 1 cycle during entry 1's pulse, len=3 -> entry 1 finishes, entry 2 is never started, seq_done with seq_aborted=1.
- len=0 -> seq_done exactly 2 edges after seq_start, bs_start never high.
- wr_en to address 0 while busy -> table[0] is unchanged on the next run. Also check bs_* fields never change while bs_start=1.
- RST asserted in RUN -> next cycle bs_start=0, seq_busy=0, datapath OUT=0. A fresh seq_start then plays the full sequence.

Source files
------------

// File: rtl/nmr_bstrm_seq.sv
// Table-driven pulse sequencer feeding the NMR bitstream datapath over a START/DONE handshake.
// Define NMR_BSTRM_SEQ_LOOP_EN to honour loop_cnt; otherwise a single pass is played.
//
// state | meaning
// IDLE  | waiting for seq_start; table writable
// LOAD  | register table[idx] onto bs_* and raise bs_start
// ACK   | bs_start high, waiting for the datapath to drop DONE
// RUN   | bs_start high, waiting for the datapath to raise DONE
// REL   | one cycle with bs_start low, then next entry / pass / finish

module nmr_bstrm_seq #(
  parameter int IDLY_WIDTH = 32,
  parameter int PLS_WIDTH  = 32,
  parameter int EDLY_WIDTH = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int LOOP_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [IDLY_WIDTH-1:0] wr_idly,
  input  logic [PLS_WIDTH-1:0]  wr_pls,
  input  logic [EDLY_WIDTH-1:0] wr_edly,
  input  logic                  seq_start,
  input  logic [DEPTH_LOG2:0]   seq_len,
  input  logic [LOOP_WIDTH-1:0] loop_cnt,
  input  logic                  abort,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic                  seq_aborted,
  output logic [DEPTH_LOG2-1:0] seq_idx,
  output logic                  bs_start,
  output logic [IDLY_WIDTH-1:0] bs_idly,
  output logic [PLS_WIDTH-1:0]  bs_pls,
  output logic [EDLY_WIDTH-1:0] bs_edly,
  input  logic                  bs_done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEN_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LEN_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACK, S_RUN, S_REL} state_t;
  state_t state, state_nxt;

  logic [IDLY_WIDTH-1:0] tbl_idly [DEPTH];
  logic [PLS_WIDTH-1:0]  tbl_pls  [DEPTH];
  logic [EDLY_WIDTH-1:0] tbl_edly [DEPTH];

  logic [DEPTH_LOG2:0]   len_clamp, len_q, idx_inc;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic idx_last, pass_last, abort_q, abort_any, zero_pend;
  logic start_ok, next_entry, next_pass, finish;

  assign seq_busy  = (state != S_IDLE);
  assign seq_idx   = idx_q;
  assign len_clamp = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;
  assign idx_inc   = {1'b0, idx_q} + LEN_ONE;
  assign idx_last  = (idx_inc >= len_q);
  assign abort_any = abort_q | abort;

`ifdef NMR_BSTRM_SEQ_LOOP_EN
  localparam logic [LOOP_WIDTH-1:0] LOOP_ONE = {{(LOOP_WIDTH-1){1'b0}}, 1'b1};
  logic [LOOP_WIDTH-1:0] pass_q, loops_q;
  logic [LOOP_WIDTH:0]   pass_inc;

  assign pass_inc  = {1'b0, pass_q} + {1'b0, LOOP_ONE};
  assign pass_last = (pass_inc >= {1'b0, loops_q});

  always_ff @(posedge CLK) begin
    if (RST) begin
      pass_q  <= '0;
      loops_q <= LOOP_ONE;
    end else if (start_ok) begin
      pass_q  <= '0;
      loops_q <= (loop_cnt == '0) ? LOOP_ONE : loop_cnt;
    end else if (next_pass) begin
      pass_q  <= pass_inc[LOOP_WIDTH-1:0];
    end
  end
`else
  logic unused_loop;
  assign unused_loop = ^{loop_cnt, next_pass};
  assign pass_last   = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (wr_en && !seq_busy) begin
      tbl_idly[wr_addr] <= wr_idly;
      tbl_pls[wr_addr]  <= wr_pls;
      tbl_edly[wr_addr] <= wr_edly;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_ok   = 1'b0;
    next_entry = 1'b0;
    next_pass  = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (seq_start && !zero_pend) begin
          start_ok = 1'b1;
          if (len_clamp != '0) state_nxt = S_LOAD;
        end
      end
      S_LOAD: state_nxt = S_ACK;
      S_ACK:  if (!bs_done) state_nxt = S_RUN;
      S_RUN:  if (bs_done) state_nxt = S_REL;
      S_REL: begin
        if (abort_any) begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
        end else if (!idx_last) begin
          next_entry = 1'b1;
          state_nxt  = S_LOAD;
        end else if (!pass_last) begin
          next_pass = 1'b1;
          state_nxt = S_LOAD;
        end else begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // An empty sequence still reports completion one cycle after the start is taken.
  always_ff @(posedge CLK) begin
    if (RST) begin
      len_q       <= '0;
      idx_q       <= '0;
      abort_q     <= 1'b0;
      zero_pend   <= 1'b0;
      seq_done    <= 1'b0;
      seq_aborted <= 1'b0;
      bs_start    <= 1'b0;
      bs_idly     <= '0;
      bs_pls      <= '0;
      bs_edly     <= '0;
    end else begin
      seq_done  <= finish | zero_pend;
      zero_pend <= start_ok && (len_clamp == '0);
      if (start_ok) begin
        len_q       <= len_clamp;
        idx_q       <= '0;
        abort_q     <= 1'b0;
        seq_aborted <= 1'b0;
      end else if (seq_busy && abort) begin
        abort_q <= 1'b1;
      end
      if (state == S_LOAD) begin
        bs_idly  <= tbl_idly[idx_q];
        bs_pls   <= tbl_pls[idx_q];
        bs_edly  <= tbl_edly[idx_q];
        bs_start <= 1'b1;
      end else if (state == S_RUN && bs_done) begin
        bs_start <= 1'b0;
      end
      if (next_entry)     idx_q <= idx_inc[DEPTH_LOG2-1:0];
      else if (next_pass) idx_q <= '0;
      if (finish) seq_aborted <= abort_any;
    end
  end

endmodule
